rob_rollback_ctrl: RTL and testbench

//   Rename-history buffer and rollback sequencer beside the 2-wide ROB. Logs every

---
 rtl/rob_rollback_ctrl.sv | 130 +++++++++++++
 tb/tb_rob_rollback_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_rollback_ctrl.sv
// rtl/rob_rollback_ctrl.sv - rename-history log with commit release and youngest-first rollback walk
module rob_rollback_ctrl #(
    parameter int DEPTH     = 16,
    parameter int TAG_WIDTH = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             alloc_valid,
    input  logic [9:0]             alloc_rd,
    input  logic [2*TAG_WIDTH-1:0] alloc_prd,
    input  logic [2*TAG_WIDTH-1:0] alloc_old_prd,
    output logic                   alloc_ready,
    input  logic [1:0]             cmt_valid,
    output logic [1:0]             rel_valid,
    output logic [2*TAG_WIDTH-1:0] rel_tag,
    input  logic                   exc_flush,
    output logic                   rb_valid,
    output logic [4:0]             rb_rd,
    output logic [TAG_WIDTH-1:0]   rb_prd,
    output logic [TAG_WIDTH-1:0]   rb_old_prd,
    output logic                   busy,
    output logic                   rb_done
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] ONE      = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] TWO      = (PTR_W+1)'(2);
    localparam logic [PTR_W:0] MAX_FILL = (PTR_W+1)'(DEPTH - 2);

    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

    state_t         state, state_nxt;
    logic [PTR_W:0] head, tail, head_nxt, tail_nxt, count;
    logic [PTR_W:0] head_p1, tail_p1, tail_m1;
    logic [PTR_W:0] cmt_req, cmt_cnt, push_cnt;
    logic           push_en;

    logic [4:0]           log_rd  [DEPTH];
    logic [TAG_WIDTH-1:0] log_prd [DEPTH];
    logic [TAG_WIDTH-1:0] log_old [DEPTH];

    assign count   = tail - head;
    assign head_p1 = head + ONE;
    assign tail_p1 = tail + ONE;
    assign tail_m1 = tail - ONE;

    assign alloc_ready = (state == IDLE) && (count <= MAX_FILL);
    assign busy        = (state != IDLE);
    assign rb_valid    = (state == WALK);
    assign rb_done     = (state == DONE);
    assign rb_rd       = log_rd[tail_m1[PTR_W-1:0]];
    assign rb_prd      = log_prd[tail_m1[PTR_W-1:0]];
    assign rb_old_prd  = log_old[tail_m1[PTR_W-1:0]];

    // 2'b10 retires nothing; a request larger than the log is clipped to what is there
    assign cmt_req  = (cmt_valid == 2'b11) ? TWO : ((cmt_valid == 2'b01) ? ONE : '0);
    assign cmt_cnt  = (state != IDLE) ? '0 : ((cmt_req > count) ? count : cmt_req);
    assign push_cnt = {{(PTR_W-1){1'b0}}, alloc_valid[1] & alloc_valid[0],
                       alloc_valid[1] ^ alloc_valid[0]};

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        push_en   = 1'b0;
        case (state)
            IDLE: begin
                head_nxt = head + cmt_cnt;
                if (exc_flush) begin
                    state_nxt = (count == cmt_cnt) ? DONE : WALK;
                end else if (alloc_ready && (alloc_valid != 2'b00)) begin
                    push_en  = 1'b1;
                    tail_nxt = tail + push_cnt;
                end
            end
            WALK: begin
                tail_nxt = tail_m1;
                if (count == ONE) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                head_nxt  = tail;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            rel_valid <= 2'b00;
            rel_tag   <= '0;
        end else begin
            state     <= state_nxt;
            head      <= head_nxt;
            tail      <= tail_nxt;
            rel_valid <= {cmt_cnt == TWO, cmt_cnt != '0};
            rel_tag   <= {log_old[head_p1[PTR_W-1:0]], log_old[head[PTR_W-1:0]]};
        end
    end

    // Lanes are compacted: a lone lane 1 lands at the tail slot
    always_ff @(posedge clk) begin
        if (push_en) begin
            if (alloc_valid[0]) begin
                log_rd[tail[PTR_W-1:0]]  <= alloc_rd[4:0];
                log_prd[tail[PTR_W-1:0]] <= alloc_prd[TAG_WIDTH-1:0];
                log_old[tail[PTR_W-1:0]] <= alloc_old_prd[TAG_WIDTH-1:0];
                if (alloc_valid[1]) begin
                    log_rd[tail_p1[PTR_W-1:0]]  <= alloc_rd[9:5];
                    log_prd[tail_p1[PTR_W-1:0]] <= alloc_prd[2*TAG_WIDTH-1:TAG_WIDTH];
                    log_old[tail_p1[PTR_W-1:0]] <= alloc_old_prd[2*TAG_WIDTH-1:TAG_WIDTH];
                end
            end else begin
                log_rd[tail[PTR_W-1:0]]  <= alloc_rd[9:5];
                log_prd[tail[PTR_W-1:0]] <= alloc_prd[2*TAG_WIDTH-1:TAG_WIDTH];
                log_old[tail[PTR_W-1:0]] <= alloc_old_prd[2*TAG_WIDTH-1:TAG_WIDTH];
            end
        end
    end

    a_cmt_pattern: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (cmt_valid != 2'b10));
    a_cmt_count: assert property (@(posedge clk) disable iff (rst)
        (state == IDLE) |-> (cmt_req <= count));

endmodule

// File: tb/tb_rob_rollback_ctrl.sv
// tb/tb_rob_rollback_ctrl.sv - scoreboard bench for rob_rollback_ctrl
module tb_rob_rollback_ctrl;
    localparam int DEPTH = 16;
    localparam int TW    = 6;

    typedef struct packed {
        logic [4:0]    rd;
        logic [TW-1:0] prd;
        logic [TW-1:0] old;
    } ent_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      alloc_valid;
    logic [9:0]      alloc_rd;
    logic [2*TW-1:0] alloc_prd;
    logic [2*TW-1:0] alloc_old_prd;
    logic            alloc_ready;
    logic [1:0]      cmt_valid;
    logic [1:0]      rel_valid;
    logic [2*TW-1:0] rel_tag;
    logic            exc_flush;
    logic            rb_valid;
    logic [4:0]      rb_rd;
    logic [TW-1:0]   rb_prd;
    logic [TW-1:0]   rb_old_prd;
    logic            busy;
    logic            rb_done;

    int checks   = 0;
    int failures = 0;
    int mtail    = 0;

    ent_t            mlog[$];
    ent_t            rb_q[$];
    logic [2*TW+1:0] rel_q[$];
    logic [2*TW+1:0] exp_rel;
    logic [2*TW+1:0] rel_obs;
    logic [2*TW+5:0] rb_obs;

    assign rel_obs = {rel_valid, rel_valid[1] ? rel_tag[2*TW-1:TW] : TW'(0),
                      rel_valid[0] ? rel_tag[TW-1:0] : TW'(0)};
    assign rb_obs  = {rb_valid, rb_rd, rb_prd, rb_old_prd};

    always #5 clk = ~clk;

    rob_rollback_ctrl #(.DEPTH(DEPTH), .TAG_WIDTH(TW)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_prd(alloc_prd),
        .alloc_old_prd(alloc_old_prd), .alloc_ready(alloc_ready),
        .cmt_valid(cmt_valid), .rel_valid(rel_valid), .rel_tag(rel_tag),
        .exc_flush(exc_flush), .rb_valid(rb_valid), .rb_rd(rb_rd), .rb_prd(rb_prd),
        .rb_old_prd(rb_old_prd), .busy(busy), .rb_done(rb_done)
    );

    function automatic ent_t mk(input int rd, input int prd, input int old);
        ent_t e;
        e.rd  = 5'(rd);
        e.prd = TW'(prd);
        e.old = TW'(old);
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        alloc_valid   = 2'b00;
        alloc_rd      = '0;
        alloc_prd     = '0;
        alloc_old_prd = '0;
        cmt_valid     = 2'b00;
        exc_flush     = 1'b0;
    endtask

    task automatic drive_alloc(input logic [1:0] v, input ent_t e0, input ent_t e1, input bit log_it);
        alloc_valid   = v;
        alloc_rd      = {e1.rd, e0.rd};
        alloc_prd     = {e1.prd, e0.prd};
        alloc_old_prd = {e1.old, e0.old};
        if (log_it && mlog.size() <= DEPTH - 2) begin
            if (v[0]) begin mlog.push_back(e0); mtail++; end
            if (v[1]) begin mlog.push_back(e1); mtail++; end
        end
    endtask

    task automatic drive_commit(input logic [1:0] v);
        logic [TW-1:0] t0, t1;
        t0 = '0;
        t1 = '0;
        cmt_valid = v;
        if (v[0]) t0 = mlog.pop_front().old;
        if (v == 2'b11) t1 = mlog.pop_front().old;
        rel_q.push_back({v, t1, t0});
    endtask

    task automatic do_flush();
        exc_flush = 1'b1;
        while (mlog.size() > 0) rb_q.push_back(mlog.pop_back());
        mtail -= rb_q.size();
    endtask

    task automatic rollback_walk(input string name);
        int   n = rb_q.size();
        ent_t e;
        for (int i = 0; i < n; i++) begin
            e = rb_q.pop_front();
            checks++;
            if (rb_obs !== {1'b1, e}) begin
                failures++;
                $display("FAIL %s rb[%0d]: got %h expected %h", name, i, rb_obs, {1'b1, e});
            end
            checks++;
            if ({busy, alloc_ready} !== 2'b10) begin
                failures++;
                $display("FAIL %s walk busy/ready[%0d]: got %b expected 10", name, i, {busy, alloc_ready});
            end
            step();
        end
        checks++;
        if ({rb_done, rb_valid, busy} !== 3'b101) begin
            failures++;
            $display("FAIL %s done done/valid/busy: got %b expected 101", name, {rb_done, rb_valid, busy});
        end
        step();
        checks++;
        if ({rb_done, busy, alloc_ready} !== 3'b001) begin
            failures++;
            $display("FAIL %s after done/busy/ready: got %b expected 001", name, {rb_done, busy, alloc_ready});
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({alloc_ready, busy, rb_valid, rb_done, rel_valid} !== 6'b100000) begin
            failures++;
            $display("FAIL reset outputs: got %b expected 100000",
                     {alloc_ready, busy, rb_valid, rb_done, rel_valid});
        end
    endtask

    task automatic test_reset_mid_walk();
        drive_alloc(2'b11, mk(1, 10, 1), mk(2, 11, 2), 1); step();
        drive_alloc(2'b11, mk(3, 12, 3), mk(4, 13, 4), 1); step();
        drive_alloc(2'b01, mk(5, 14, 5), mk(0, 0, 0), 1); step();
        idle_inputs();
        do_flush();
        step();
        idle_inputs();
        step();
        step();
        checks++;
        if (rb_obs !== {1'b1, mk(3, 12, 3)}) begin
            failures++;
            $display("FAIL mid_walk third rb: got %h expected %h", rb_obs, {1'b1, mk(3, 12, 3)});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({rb_valid, busy} !== 2'b00) begin
            failures++;
            $display("FAIL mid_walk async reset valid/busy: got %b expected 00", {rb_valid, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        mlog.delete();
        rb_q.delete();
        rel_q.delete();
        mtail = 0;
        step();
        checks++;
        if ({alloc_ready, busy, rb_valid} !== 3'b100) begin
            failures++;
            $display("FAIL mid_walk post reset ready/busy/valid: got %b expected 100",
                     {alloc_ready, busy, rb_valid});
        end
    endtask

    task automatic test_full_window();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (alloc_ready !== 1'b1) begin
                failures++;
                $display("FAIL full ready at count %0d: got %b expected 1", 2 * i, alloc_ready);
            end
            drive_alloc(2'b11, mk(i, 2 * i, 2 * i + 1), mk(i + 8, 2 * i + 16, 2 * i + 17), 1);
            step();
        end
        idle_inputs();
        checks++;
        if (alloc_ready !== 1'b0) begin
            failures++;
            $display("FAIL full ready at count 16: got %b expected 0", alloc_ready);
        end
        drive_alloc(2'b11, mk(30, 60, 61), mk(31, 62, 63), 1);
        step();
        idle_inputs();
        checks++;
        if (alloc_ready !== 1'b0) begin
            failures++;
            $display("FAIL full ready after dropped alloc: got %b expected 0", alloc_ready);
        end
        for (int j = 0; j < 8; j++) begin
            drive_commit(2'b11);
            step();
            exp_rel = rel_q.pop_front();
            checks++;
            if (rel_obs !== exp_rel) begin
                failures++;
                $display("FAIL full release %0d: got %h expected %h", j, rel_obs, exp_rel);
            end
            if (j == 0) begin
                checks++;
                if (alloc_ready !== 1'b1) begin
                    failures++;
                    $display("FAIL full ready after commit: got %b expected 1", alloc_ready);
                end
            end
        end
        idle_inputs();
        step();
        checks++;
        if (rel_valid !== 2'b00) begin
            failures++;
            $display("FAIL full release idle: got %b expected 00", rel_valid);
        end
    endtask

    task automatic test_commit();
        drive_alloc(2'b11, mk(1, 33, 1), mk(2, 34, 2), 1);
        step();
        idle_inputs();
        drive_commit(2'b11);
        step();
        idle_inputs();
        exp_rel = rel_q.pop_front();
        checks++;
        if (rel_obs !== exp_rel || exp_rel !== {2'b11, 6'd2, 6'd1}) begin
            failures++;
            $display("FAIL commit release: got %h expected %h", rel_obs, {2'b11, 6'd2, 6'd1});
        end
        step();
        checks++;
        if (rel_valid !== 2'b00) begin
            failures++;
            $display("FAIL commit release pulse: got %b expected 00", rel_valid);
        end
    endtask

    task automatic test_rollback_order();
        drive_alloc(2'b11, mk(5, 40, 12), mk(5, 41, 40), 1);
        step();
        drive_alloc(2'b01, mk(6, 42, 13), mk(0, 0, 0), 1);
        step();
        idle_inputs();
        do_flush();
        step();
        idle_inputs();
        rollback_walk("order");
    endtask

    task automatic test_empty_flush();
        do_flush();
        step();
        idle_inputs();
        rollback_walk("empty");
    endtask

    task automatic test_commit_flush();
        drive_alloc(2'b11, mk(7, 50, 20), mk(8, 51, 21), 1);
        step();
        drive_alloc(2'b01, mk(9, 52, 22), mk(0, 0, 0), 1);
        step();
        idle_inputs();
        drive_alloc(2'b11, mk(10, 60, 23), mk(11, 61, 24), 0);
        drive_commit(2'b01);
        do_flush();
        step();
        idle_inputs();
        exp_rel = rel_q.pop_front();
        checks++;
        if (rel_obs !== exp_rel) begin
            failures++;
            $display("FAIL cflush release: got %h expected %h", rel_obs, exp_rel);
        end
        rollback_walk("cflush");
        do_flush();
        step();
        idle_inputs();
        rollback_walk("cflush_nolog");
    endtask

    task automatic test_wrap();
        int guard = 0;
        while ((mtail % DEPTH) != 15 && guard < 40) begin
            guard++;
            drive_alloc(2'b01, mk(guard, guard, guard + 1), mk(0, 0, 0), 1);
            step();
            idle_inputs();
            drive_commit(2'b01);
            step();
            idle_inputs();
            exp_rel = rel_q.pop_front();
            checks++;
            if (rel_obs !== exp_rel) begin
                failures++;
                $display("FAIL wrap advance release %0d: got %h expected %h", guard, rel_obs, exp_rel);
            end
        end
        drive_alloc(2'b11, mk(20, 44, 3), mk(21, 45, 4), 1);
        step();
        drive_alloc(2'b10, mk(0, 0, 0), mk(20, 46, 44), 1);
        step();
        idle_inputs();
        checks++;
        if (mlog.size() !== 3) begin
            failures++;
            $display("FAIL wrap setup model entries: got %0d expected 3", mlog.size());
        end
        do_flush();
        step();
        idle_inputs();
        rollback_walk("wrap");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_reset_mid_walk();
        test_full_window();
        test_commit();
        test_rollback_order();
        test_empty_flush();
        test_commit_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
